// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read port.
//   master (fetch unit): drives imem_req/imem_addr, receives imem_rdata/imem_rvalid
//   slave  (memory)    : receives imem_req/imem_addr, drives imem_rdata/imem_rvalid
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_rvalid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_rvalid
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: IDLE -> FETCH -> WAIT -> VALID loop with branch
// redirect, downstream stall hold and a bounded memory wait (timeout -> NOP).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   imem              instruction memory port (master side)
//   branch_taken/_target  redirect request from execute
//   stall             downstream cannot accept the held instruction
//   instr_valid, instr, pc_out, pc_plus4, opCode/rs/rt/rd/funct/imm
//   fetch_err         one-cycle pulse on a fetch timeout
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_unit_if.master  imem,
    input  logic                branch_taken,
    input  logic [31:0]         branch_target,
    input  logic                stall,
    output logic                instr_valid,
    output logic [31:0]         instr,
    output logic [31:0]         pc_out,
    output logic [31:0]         pc_plus4,
    output logic [5:0]          opCode,
    output logic [4:0]          rs,
    output logic [4:0]          rt,
    output logic [4:0]          rd,
    output logic [5:0]          funct,
    output logic [15:0]         imm,
    output logic                fetch_err
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_VALID = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [31:0]        pc, pc_nxt;
    logic [31:0]        instr_nxt;
    logic [CNT_W-1:0]   wait_cnt, wait_cnt_nxt;
    logic               fetch_err_nxt;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            instr     <= '0;
            wait_cnt  <= '0;
            fetch_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            instr     <= instr_nxt;
            wait_cnt  <= wait_cnt_nxt;
            fetch_err <= fetch_err_nxt;
        end
    end

    // Next-state and datapath update; a redirect beats everything but IDLE
    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        instr_nxt     = instr;
        wait_cnt_nxt  = wait_cnt;
        fetch_err_nxt = 1'b0;

        if (branch_taken && (state != S_IDLE)) begin
            state_nxt = S_FETCH;
            pc_nxt    = {branch_target[31:2], 2'b00};
            instr_nxt = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nxt = S_FETCH;
                end
                S_FETCH: begin
                    state_nxt    = S_WAIT;
                    wait_cnt_nxt = '0;
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        instr_nxt = imem.imem_rdata;
                        state_nxt = S_VALID;
                    end else begin
                        wait_cnt_nxt = wait_cnt + CNT_W'(1);
                        // This miss is the MAX_WAIT-th: give up and hand over a NOP
                        if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
                            instr_nxt     = '0;
                            fetch_err_nxt = 1'b1;
                            state_nxt     = S_VALID;
                        end
                    end
                end
                S_VALID: begin
                    if (!stall) begin
                        pc_nxt    = pc + 32'd4;
                        state_nxt = S_FETCH;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Request/valid decode from state, forced low while reset is held
    assign imem.imem_req  = (state == S_FETCH) && !rst;
    assign imem.imem_addr = pc;
    assign instr_valid    = (state == S_VALID) && !rst;

    assign pc_out   = pc;
    assign pc_plus4 = pc + 32'd4;

    assign opCode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, stall, redirects,
// timeout, reset mid-WAIT, and PC wrap on a second instance.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, rst1;
    logic        branch_taken, stall;
    logic [31:0] branch_target;

    instr_fetch_unit_if bus0 ();
    instr_fetch_unit_if bus1 ();

    logic        instr_valid, fetch_err, instr_valid1, fetch_err1;
    logic [31:0] instr, pc_out, pc_plus4, instr1, pc_out1, pc_plus41;
    logic [5:0]  opCode, funct, opCode1, funct1;
    logic [4:0]  rs, rt, rd, rs1, rt1, rd1;
    logic [15:0] imm, imm1;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] D0 = 32'h0109_5020;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst), .imem(bus0.master),
        .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall),
        .instr_valid(instr_valid), .instr(instr), .pc_out(pc_out), .pc_plus4(pc_plus4),
        .opCode(opCode), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm),
        .fetch_err(fetch_err)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .MAX_WAIT(8)) dut_wrap (
        .clk(clk), .rst(rst1), .imem(bus1.master),
        .branch_taken(1'b0), .branch_target(32'h0), .stall(1'b0),
        .instr_valid(instr_valid1), .instr(instr1), .pc_out(pc_out1), .pc_plus4(pc_plus41),
        .opCode(opCode1), .rs(rs1), .rt(rt1), .rd(rd1), .funct(funct1), .imm(imm1),
        .fetch_err(fetch_err1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects FETCH now; memory answers one cycle later; ends in VALID
    task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data);
        check("req_fetch", 32'(bus0.imem_req), 32'd1);
        check("addr_fetch", bus0.imem_addr, addr);
        tick();
        check("req_wait", 32'(bus0.imem_req), 32'd0);
        bus0.imem_rvalid = 1'b1;
        bus0.imem_rdata  = data;
        tick();
        bus0.imem_rvalid = 1'b0;
        check("valid", 32'(instr_valid), 32'd1);
        check("instr", instr, data);
        check("pc_out", pc_out, addr);
    endtask

    initial begin
        rst = 1'b1; rst1 = 1'b1;
        branch_taken = 1'b0; branch_target = 32'h0; stall = 1'b0;
        bus0.imem_rvalid = 1'b0; bus0.imem_rdata = 32'h0;
        bus1.imem_rvalid = 1'b0; bus1.imem_rdata = 32'h0;
        tick();
        tick();
        check("rst_req", 32'(bus0.imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_pc", pc_out, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_err", 32'(fetch_err), 32'd0);

        // Sequential fetch
        rst = 1'b0;
        check("idle_req", 32'(bus0.imem_req), 32'd0);
        tick();
        fetch_one(32'h0, D0);
        check("opCode", 32'(opCode), 32'd0);
        check("funct", 32'(funct), 32'h20);
        check("rd", 32'(rd), 32'd10);
        check("rs", 32'(rs), 32'd8);
        check("rt", 32'(rt), 32'd9);
        check("imm", 32'(imm), 32'h5020);
        check("pc_plus4", pc_plus4, 32'h4);
        tick();
        fetch_one(32'h4, D0);
        tick();
        fetch_one(32'h8, D0);

        // Stall hold for 5 cycles
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_pc", pc_out, 32'h8);
            check("stall_instr", instr, D0);
            check("stall_req", 32'(bus0.imem_req), 32'd0);
        end
        stall = 1'b0;
        tick();
        check("after_stall_addr", bus0.imem_addr, 32'hC);

        // Redirect in WAIT with coincident rvalid
        tick();
        bus0.imem_rvalid = 1'b1; bus0.imem_rdata = 32'hDEAD_BEEF;
        branch_taken = 1'b1; branch_target = 32'h0000_0043;
        tick();
        bus0.imem_rvalid = 1'b0; branch_taken = 1'b0;
        check("redir_valid", 32'(instr_valid), 32'd0);
        check("redir_instr", instr, 32'h0);
        fetch_one(32'h40, 32'h2008_0005);

        // Timeout after 8 WAIT cycles
        tick();
        check("to_addr", bus0.imem_addr, 32'h44);
        tick();
        for (int i = 0; i < 7; i++) begin
            tick();
            check("to_wait_err", 32'(fetch_err), 32'd0);
            check("to_wait_valid", 32'(instr_valid), 32'd0);
        end
        tick();
        check("to_err", 32'(fetch_err), 32'd1);
        check("to_valid", 32'(instr_valid), 32'd1);
        check("to_instr", instr, 32'h0);
        check("to_pc", pc_out, 32'h44);
        stall = 1'b1;
        tick();
        check("to_err_pulse", 32'(fetch_err), 32'd0);
        check("to_hold_pc", pc_out, 32'h44);
        stall = 1'b0;
        tick();
        fetch_one(32'h48, D0);

        // Redirect with stall in VALID
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h100;
        tick();
        stall = 1'b0; branch_taken = 1'b0;
        check("rs_addr", bus0.imem_addr, 32'h100);
        check("rs_req", 32'(bus0.imem_req), 32'd1);
        check("rs_valid", 32'(instr_valid), 32'd0);

        // Redirect coinciding with timeout
        tick();
        for (int i = 0; i < 7; i++) tick();
        branch_taken = 1'b1; branch_target = 32'h200;
        tick();
        branch_taken = 1'b0;
        check("rt_err", 32'(fetch_err), 32'd0);
        check("rt_addr", bus0.imem_addr, 32'h200);
        check("rt_req", 32'(bus0.imem_req), 32'd1);

        // Reset mid-WAIT at pc 0x20, overriding branch/stall
        branch_taken = 1'b1; branch_target = 32'h20;
        tick();
        branch_taken = 1'b0;
        check("pre_rst_addr", bus0.imem_addr, 32'h20);
        tick();
        rst = 1'b1; branch_taken = 1'b1; branch_target = 32'h80; stall = 1'b1;
        bus0.imem_rvalid = 1'b1; bus0.imem_rdata = 32'hDEAD_BEEF;
        tick();
        check("mid_rst_req", 32'(bus0.imem_req), 32'd0);
        check("mid_rst_pc", pc_out, 32'h0);
        check("mid_rst_instr", instr, 32'h0);
        rst = 1'b0; branch_taken = 1'b0; stall = 1'b0;
        tick();
        check("late_rv_addr", bus0.imem_addr, 32'h0);
        check("late_rv_req", 32'(bus0.imem_req), 32'd1);
        check("late_rv_instr", instr, 32'h0);
        check("late_rv_valid", 32'(instr_valid), 32'd0);
        tick();
        bus0.imem_rvalid = 1'b0;
        tick();
        check("fetch_rv_ignored", 32'(instr_valid), 32'd0);
        bus0.imem_rvalid = 1'b1; bus0.imem_rdata = 32'h1234_5678;
        tick();
        bus0.imem_rvalid = 1'b0;
        check("restart_instr", instr, 32'h1234_5678);
        check("restart_pc", pc_out, 32'h0);

        // PC wrap on second instance
        rst1 = 1'b0;
        tick();
        check("wrap_addr0", bus1.imem_addr, 32'hFFFF_FFFC);
        check("wrap_plus4", pc_plus41, 32'h0);
        tick();
        bus1.imem_rvalid = 1'b1; bus1.imem_rdata = D0;
        tick();
        bus1.imem_rvalid = 1'b0;
        check("wrap_valid", 32'(instr_valid1), 32'd1);
        tick();
        check("wrap_addr1", bus1.imem_addr, 32'h0);
        check("wrap_req", 32'(bus1.imem_req), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
